// File: rtl/alu_muldiv_seq.sv
// Sequential unsigned multiply/divide controller driving an external adder ALU.
// Multiply is 24-cycle shift-add, divide is 24-cycle restoring division;
// divide-by-zero short-circuits straight to DONE with a fixed result.
//
// state | meaning
// IDLE  | ready for a new request, results hold the last completed operation
// MUL   | one shift-add iteration per cycle
// DIV   | one restoring-division iteration per cycle
// DONE  | one-cycle completion pulse, then back to IDLE
module alu_muldiv_seq #(
  parameter logic [2:0] ALUOP_ADD = 3'b010,
  parameter int         WIDTH     = 24
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_a_invert,
  output logic             alu_b_negate,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry_out
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] work_hi;  // product high half / partial remainder
  logic [WIDTH-1:0] work_lo;  // product low half (multiplier bits) / quotient
  logic [CW-1:0]    cnt;
  logic             last_iter;
  logic             accept_dbz;

  logic [WIDTH:0]   div_t;
  logic             div_bit;
  logic [WIDTH-1:0] div_r_nxt;
  logic [WIDTH-1:0] div_q_nxt;
  logic [WIDTH-1:0] mul_hi_nxt;
  logic [WIDTH-1:0] mul_lo_nxt;

  assign last_iter  = (cnt == CW'(WIDTH - 1));
  assign accept_dbz = op && (op_b == '0);

  // The shifted-in dividend bit can push T past 24 bits; T[24] then
  // guarantees T >= divisor regardless of what the 24-bit ALU reports.
  assign div_t     = {work_hi, work_lo[WIDTH-1]};
  assign div_bit   = div_t[WIDTH] | alu_carry_out;
  assign div_r_nxt = div_bit ? alu_result : div_t[WIDTH-1:0];
  assign div_q_nxt = {work_lo[WIDTH-2:0], div_bit};

  assign {mul_hi_nxt, mul_lo_nxt} = {alu_carry_out, alu_result, work_lo[WIDTH-1:1]};

  assign ready        = (state == IDLE);
  assign done         = (state == DONE);
  assign alu_a_invert = 1'b0;
  assign alu_op       = ALUOP_ADD;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and ALU operand steering
  always_comb begin
    state_nxt    = state;
    alu_a        = '0;
    alu_b        = '0;
    alu_b_negate = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (accept_dbz) state_nxt = DONE;
          else if (op)    state_nxt = DIV;
          else            state_nxt = MUL;
        end
      end
      MUL: begin
        alu_a = work_hi;
        alu_b = work_lo[0] ? opb_q : '0;
        if (last_iter) state_nxt = DONE;
      end
      DIV: begin
        alu_a        = div_t[WIDTH-1:0];
        alu_b        = opb_q;
        alu_b_negate = 1'b1;
        if (last_iter) state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration updates, result publication
  always_ff @(posedge clock) begin
    if (reset) begin
      opb_q       <= '0;
      work_hi     <= '0;
      work_lo     <= '0;
      cnt         <= '0;
      div_by_zero <= 1'b0;
      result_hi   <= '0;
      result_lo   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            opb_q       <= op_b;
            work_hi     <= '0;
            work_lo     <= op_a;
            cnt         <= '0;
            div_by_zero <= accept_dbz;
            if (accept_dbz) begin
              result_hi <= op_a;
              result_lo <= '1;
            end
          end
        end
        MUL: begin
          work_hi <= mul_hi_nxt;
          work_lo <= mul_lo_nxt;
          cnt     <= cnt + 1'b1;
          if (last_iter) begin
            result_hi <= mul_hi_nxt;
            result_lo <= mul_lo_nxt;
          end
        end
        DIV: begin
          work_hi <= div_r_nxt;
          work_lo <= div_q_nxt;
          cnt     <= cnt + 1'b1;
          if (last_iter) begin
            result_hi <= div_r_nxt;
            result_lo <= div_q_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/alu_muldiv_seq.md
ALU_MULDIV_SEQ -- requirements
Module: alu_muldiv_seq

Interface
REQ-001 Parameter ALUOP_ADD, default 3'b010, ALUOp code selecting the ALU add/subtract path.
REQ-002 Parameter WIDTH, default 24, operand width; all requirements below are written for WIDTH=24.
REQ-003 Clock  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  reset is synchronous and active-high.
REQ-005 Start  input  1  request; accepted only when Ready=1.
REQ-006 Op  input  1  0=unsigned multiply, 1=unsigned divide; sampled at accept.
REQ-007 OpA, OpB  input  24 each  multiplicand/multiplier or dividend/divisor; sampled at accept.
REQ-008 Ready  output  1  high in IDLE only.
REQ-009 Done  output  1  one-cycle pulse; results valid from that cycle.
REQ-010 ResultHi, ResultLo  output  24 each  product {Hi,Lo}, or Hi=remainder, Lo=quotient.
REQ-011 DivByZero  output  1  set with Done when divide and OpB=0; held until next accept.
REQ-012 AluA, AluB  output  24 each  ALU operand drives.
REQ-013 AluAInvert, AluBNegate  output  1 each  ALU invert/negate controls; AluAInvert is always 0.
REQ-014 AluOp  output  3  always ALUOP_ADD.
REQ-015 AluResult  input  24  ALU result, combinational from the drives.
REQ-016 AluCarryOut  input  1  ALU carry; on subtract (AluBNegate=1), 1 means no borrow (AluA>=AluB).

Function
REQ-017 FSM states IDLE, MUL, DIV, DONE; reset state IDLE.
REQ-018 IDLE: Start=1 latches Op/OpA/OpB, clears the iteration counter, and moves to MUL or DIV; if Op=1 and OpB=0, it moves directly to DONE.
REQ-019 Start while not IDLE is ignored, with no effect on state or outputs.
REQ-020 MUL uses shift-add with P={Hi,Lo}, Hi=0, Lo=OpA at accept; each cycle: AluA=Hi, AluB=(Lo[0]?OpB:0), AluBNegate=0; {Hi,Lo} <= {AluCarryOut,AluResult,Lo[23:1]}.
REQ-021 DIV uses restoring division with R=0, Q=OpA at accept; each cycle: T={R,Q[23]} is 25 bits; AluA=T[23:0], AluB=OpB, AluBNegate=1.
REQ-022 In DIV, if T[24]=1 or AluCarryOut=1, then R<=AluResult and the new quotient bit is 1; else R<=T[23:0] and the bit is 0; Q<={Q[22:0],bit}.
REQ-023 Exactly 24 iteration cycles occur in MUL/DIV (counter 0..23); after counter=23 the FSM goes to DONE.
REQ-024 DONE lasts one cycle with Done=1, then the FSM returns to IDLE; Ready=0 in DONE.
REQ-025 Latency: with accept at edge N, Done=1 during cycle N+25; for divide-by-zero, Done=1 during cycle N+1.
REQ-026 Divide-by-zero result: ResultLo=24'hFFFFFF, ResultHi=OpA, DivByZero=1; no ALU iterations.
REQ-027 ResultHi/ResultLo hold the last completed result in IDLE; they change only during MUL/DIV and at divide-by-zero completion.
REQ-028 Outside MUL/DIV: AluA=0, AluB=0, AluBNegate=0.
REQ-029 Back-to-back: Start high in the IDLE cycle right after DONE is accepted, giving minimum issue interval 26 cycles.

Reset
REQ-030 Reset=1 at any edge forces IDLE, even mid-operation; the in-flight operation is abandoned and produces no Done.
REQ-031 Reset values: Ready=1 (first cycle after reset), Done=0, DivByZero=0, ResultHi=0, ResultLo=0, counter=0, Alu drives per REQ-028.
REQ-032 Reset has priority over Start in the same cycle.

Verification (bench connects the team's 24-bit ALU to the Alu* ports)
REQ-033 Mul OpA=3, OpB=5 -> Done at N+25, ResultHi=0, ResultLo=15, DivByZero=0.
REQ-034 Mul OpA=OpB=24'hFFFFFF -> ResultHi=24'hFFFFFE, ResultLo=24'h000001.
REQ-035 Div OpA=100, OpB=7 -> ResultLo=14, ResultHi=2; Div 24'hFFFFFF/1 -> ResultLo=24'hFFFFFF, ResultHi=0.
REQ-036 Div OpA=50, OpB=0 -> Done at N+1, DivByZero=1, ResultLo=24'hFFFFFF, ResultHi=50.
REQ-037 Start pulsed at cycle N+10 of a multiply with different operands -> ignored; first result unchanged; single Done.
REQ-038 Reset asserted at iteration 10 of a divide -> no Done, Ready=1 the next cycle, results=0; the next multiply 3*5 yields 15.
